apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master.sv | 130 +++++++++++++
 tb/tb_apb_master.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// APB master: one command in, one APB transfer out, one-cycle response pulse.
// Ports: pclk/PRESETn, cmd_* request, rsp_* completion, p* APB master side.
module apb_master #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  pclk,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  localparam logic [8:0] TO_LIM = TIMEOUT[8:0];

  logic [1:0]            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  run_q;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rv_q, rv_d;
  logic [DATA_WIDTH-1:0] rd_q, rd_d;
  logic                  err_q, err_d;
  logic                  to_q, to_d;
  logic [8:0]            cnt_inc;

  assign cnt_inc = {1'b0, cnt_q} + 9'd1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    rv_d     = 1'b0;
    rd_d     = rd_q;
    err_d    = err_q;
    to_d     = to_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && run_q) begin
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_write ? cmd_wdata : '0;
          cnt_d    = '0;
          state_d  = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready) begin
          rv_d    = 1'b1;
          rd_d    = pwrite_q ? '0 : prdata;
          err_d   = pslverr;
          to_d    = 1'b0;
          state_d = IDLE;
        end else if (cnt_inc == TO_LIM) begin
          // slave never answered: abort with a timeout response
          rv_d    = 1'b1;
          rd_d    = '0;
          err_d   = 1'b1;
          to_d    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc[7:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      rv_q     <= 1'b0;
      rd_q     <= '0;
      err_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      run_q    <= 1'b1;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      rv_q     <= rv_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
      to_q     <= to_d;
    end
  end

  // run_q keeps cmd_ready low until the first edge after reset release
  assign cmd_ready   = (state_q == IDLE) && run_q;
  assign psel        = (state_q == SETUP) || (state_q == ACCESS);
  assign penable     = (state_q == ACCESS);
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rv_q;
  assign rsp_rdata   = rd_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = to_q;

endmodule

// File: tb/tb_apb_master.sv
// Testbench for apb_master: random transfers against a memory-backed APB
// slave, checked by a transaction-level latency/response model.
module tb_apb_master;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          pclk = 1'b0;
  logic          PRESETn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- slave model ----------------
  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] ref_mem [0:1023];
  int            slv_waits = 0;
  logic          slv_err = 1'b0;
  int            acc_cnt = 0;
  logic [DW-1:0] junk = '0;
  logic          junk_b = 1'b0;

  assign pready  = psel && penable && (acc_cnt >= slv_waits);
  assign prdata  = pready ? mem[paddr] : junk;
  assign pslverr = pready ? slv_err : junk_b;

  always @(posedge pclk or negedge PRESETn) begin
    if (!PRESETn) acc_cnt <= 0;
    else if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  always @(posedge pclk)
    if (PRESETn && pready && pwrite && !slv_err) mem[paddr] <= pwdata;

  always @(negedge pclk) begin
    junk   = $urandom;
    junk_b = 1'($urandom_range(0, 1));
  end

  // ---------------- transaction ----------------
  // Entered and left at a negedge.
  task automatic txn(input logic w, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input int waits,
                     input logic e);
    int n, ps, pe, unstable, lat;
    logic [DW-1:0] erd;
    logic eerr, eto;
    bit timed;
    timed = (waits >= TO);
    lat   = timed ? 2 + TO : 3 + waits;
    eerr  = timed ? 1'b1 : e;
    eto   = timed;
    erd   = (timed || w) ? '0 : ref_mem[a];
    if (!timed && w && !e) ref_mem[a] = d;
    slv_waits = waits;
    slv_err   = e;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    chk("ready", 32'(cmd_ready), 32'd1);
    @(posedge pclk);
    @(negedge pclk);
    cmd_valid = 1'b0;
    cmd_addr  = AW'($urandom);
    cmd_wdata = $urandom;
    cmd_write = 1'($urandom_range(0, 1));
    n = 1; ps = 0; pe = 0; unstable = 0;
    while (!rsp_valid && n <= 40) begin
      if (psel) begin
        ps++;
        if (paddr !== a || pwrite !== w ||
            pwdata !== (w ? d : '0)) unstable++;
      end
      if (penable) pe++;
      n++;
      @(negedge pclk);
    end
    if (n > 40) begin
      chk("rsp_wait", 32'(n), 32'(lat));
    end else begin
      chk("latency", 32'(n), 32'(lat));
      chk("psel_cyc", 32'(ps), 32'(timed ? TO + 1 : waits + 2));
      chk("pen_cyc", 32'(pe), 32'(timed ? TO : waits + 1));
      chk("stable", 32'(unstable), 32'd0);
      chk("rdata", rsp_rdata, erd);
      chk("err", 32'(rsp_err), 32'(eerr));
      chk("tmo", 32'(rsp_timeout), 32'(eto));
      chk("psel_idle", 32'({psel, penable}), 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    #2;
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_psel", 32'({psel, penable, pwrite}), 32'd0);
    chk("rst_paddr", 32'(paddr), 32'd0);
    chk("rst_rsp", 32'({rsp_valid, rsp_err, rsp_timeout}), 32'd0);
    repeat (2) @(negedge pclk);
    PRESETn = 1'b1;
    @(negedge pclk);

    txn(1'b1, 10'h3, 32'hDEADBEEF, 0, 1'b0);
    txn(1'b0, 10'h3, 32'h0, 0, 1'b0);
    chk("rd_pwrite", 32'(pwrite), 32'd0);
    chk("rd_pwdata", pwdata, 32'd0);
    txn(1'b0, 10'h5, 32'h0, 2, 1'b0);
    txn(1'b0, 10'h6, 32'h0, 255, 1'b0);
    txn(1'b0, 10'h7, 32'h0, 3, 1'b0);
    txn(1'b1, 10'h8, 32'h12345678, 1, 1'b1);
    txn(1'b0, 10'h8, 32'h0, 0, 1'b1);

    // reset while in ACCESS
    slv_waits = 255;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 10'h9;
    @(posedge pclk);
    @(negedge pclk);
    cmd_valid = 1'b0;
    @(negedge pclk);
    chk("in_access", 32'({psel, penable}), 32'd3);
    #2 PRESETn = 1'b0;
    #1;
    chk("rst_async", 32'({psel, penable, cmd_ready}), 32'd0);
    begin
      int seen;
      seen = 0;
      repeat (3) begin
        @(negedge pclk);
        if (rsp_valid) seen++;
      end
      PRESETn = 1'b1;
      repeat (2) begin
        @(negedge pclk);
        if (rsp_valid) seen++;
      end
      chk("rst_no_rsp", 32'(seen), 32'd0);
    end
    txn(1'b0, 10'h3, 32'h0, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      int wsel;
      wsel = $urandom_range(0, 6);
      txn(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
          $urandom, (wsel == 6) ? 7 : wsel,
          ($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
